// File: rtl/mc_control.sv
// rtl/mc_control.sv - multicycle RV32I control FSM driving datapath selects, write enables and ALU op
module mc_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [4:0] alu_ctrl,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_OR  = 5'b00011;
  localparam logic [4:0] ALU_XOR = 5'b00100;
  localparam logic [4:0] ALU_SLL = 5'b00101;
  localparam logic [4:0] ALU_SRL = 5'b00110;
  localparam logic [4:0] ALU_SRA = 5'b00111;

  state_t     state;
  state_t     state_next;
  logic       dec_illegal;
  logic [4:0] func_op;

  // R-type and I-ALU reject funct3 010/011; branches accept only funct3 000
  always_comb begin
    dec_illegal = 1'b0;
    case (opcode)
      OP_LOAD, OP_STORE, OP_JAL: dec_illegal = 1'b0;
      OP_R, OP_I:                dec_illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
      OP_BEQ:                    dec_illegal = (funct3 != 3'b000);
      default:                   dec_illegal = 1'b1;
    endcase
  end

  // funct7_5 selects sub only for register ops; addi's bit 30 is immediate data
  always_comb begin
    func_op = ALU_ADD;
    case (funct3)
      3'b000:  func_op = (funct7_5 && state == S_EXECR) ? ALU_SUB : ALU_ADD;
      3'b111:  func_op = ALU_AND;
      3'b110:  func_op = ALU_OR;
      3'b100:  func_op = ALU_XOR;
      3'b001:  func_op = ALU_SLL;
      3'b101:  func_op = funct7_5 ? ALU_SRA : ALU_SRL;
      default: func_op = ALU_ADD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH: begin
        if (mem_ready) begin
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_illegal) begin
          state_next = S_FETCH;
        end else begin
          case (opcode)
            OP_LOAD, OP_STORE: state_next = S_MEMADR;
            OP_R:              state_next = S_EXECR;
            OP_I:              state_next = S_EXECI;
            OP_JAL:            state_next = S_JAL;
            OP_BEQ:            state_next = S_BEQ;
            default:           state_next = S_FETCH;
          endcase
        end
      end
      S_MEMADR:   state_next = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_next = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: state_next = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    state_next = S_ALUWB;
      S_EXECI:    state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_JAL:      state_next = S_ALUWB;
      S_BEQ:      state_next = S_FETCH;
      default:    state_next = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_ctrl   = ALU_ADD;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        result_src = 2'b10;
        alu_src_b  = 2'b10;
        pc_write   = mem_ready;
        ir_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        illegal   = dec_illegal;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_ctrl  = func_op;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_ctrl  = func_op;
      end
      S_ALUWB: reg_write = 1'b1;
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_ctrl  = ALU_SUB;
        pc_write  = zero;
      end
      default: ;
    endcase
    // reset kills any in-flight write in the same cycle it rises
    if (rst) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
    end
  end

endmodule
